// File: rtl/ofs_asp_irq_ctrl.sv
// ofs_asp_irq_ctrl
//   Interrupt aggregator/sequencer for the ASP. Rising edges on the DMA_0 (bit0), kernel (bit1)
//   and DMA_1 (bit2) IRQ sources are latched into a host-visible STATUS CSR. Unmasked pending
//   sources are serialised into single-vector requests toward the host-channel interrupt port
//   over a valid/ready handshake, with a hold-off gap after every accepted request.
//
//   Ports
//     clk, reset                  single clock, asynchronous active-high reset
//     irq_src                     level IRQ sources, synchronous to clk
//     csr_address/write/writedata CSR write port (word address, single-cycle strobe)
//     csr_read                    CSR read strobe (single cycle)
//     csr_readdata/readdatavalid  read response, one cycle after csr_read
//     irq_req_valid/vector/ready  interrupt request handshake toward the host channel
//
//   CSR map (word address): 0 STATUS (RW1C), 1 MASK (RW, 1 = masked), 2 GLOBAL_EN (bit0),
//   3 COUNT (RO, accepted requests), 4 INFLIGHT (RO). Other addresses read 0.
module ofs_asp_irq_ctrl #(
    parameter int unsigned NUM_IRQ_LINES  = 4,
    parameter int unsigned NUM_IRQ_USED   = 3,
    parameter int unsigned CSR_DATA_WIDTH = 64,
    parameter int unsigned CSR_ADDR_WIDTH = 3,
    parameter int unsigned HOLDOFF_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_IRQ_USED-1:0]          irq_src,
    input  logic [CSR_ADDR_WIDTH-1:0]        csr_address,
    input  logic                             csr_write,
    input  logic [CSR_DATA_WIDTH-1:0]        csr_writedata,
    input  logic                             csr_read,
    output logic [CSR_DATA_WIDTH-1:0]        csr_readdata,
    output logic                             csr_readdatavalid,
    output logic                             irq_req_valid,
    output logic [$clog2(NUM_IRQ_LINES)-1:0] irq_req_vector,
    input  logic                             irq_req_ready
);

    localparam int unsigned VecW  = $clog2(NUM_IRQ_LINES);
    localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [CSR_ADDR_WIDTH-1:0] AddrStatus   = CSR_ADDR_WIDTH'(0);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMask     = CSR_ADDR_WIDTH'(1);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrGlobalEn = CSR_ADDR_WIDTH'(2);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrCount    = CSR_ADDR_WIDTH'(3);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrInflight = CSR_ADDR_WIDTH'(4);

    typedef enum logic [1:0] {StIdle, StReq, StHoldoff} state_e;

    state_e                      state_q, state_d;
    logic [NUM_IRQ_USED-1:0]     src_q;
    logic [NUM_IRQ_USED-1:0]     status_q, status_d;
    logic [NUM_IRQ_USED-1:0]     mask_q, mask_d;
    logic [NUM_IRQ_USED-1:0]     inflight_q, inflight_d;
    logic                        global_en_q, global_en_d;
    logic [31:0]                 count_q, count_d;
    logic [VecW-1:0]             vec_q, vec_d;
    logic [HoldW-1:0]            hold_q, hold_d;
    logic [CSR_DATA_WIDTH-1:0]   readdata_q, rd_data;
    logic                        readdatavalid_q;

    logic [NUM_IRQ_USED-1:0]     rise, w1c, eligible, acc_onehot;
    logic [VecW-1:0]             pick_vec;
    logic                        accept;
    logic                        unused_wdata;

    assign unused_wdata = ^csr_writedata[CSR_DATA_WIDTH-1:NUM_IRQ_USED];

    // ---------------- CSR and IRQ bookkeeping ----------------
    always_comb begin
        rise     = irq_src & ~src_q;
        w1c      = (csr_write && csr_address == AddrStatus) ?
                   csr_writedata[NUM_IRQ_USED-1:0] : '0;
        accept   = (state_q == StReq) && irq_req_ready;
        for (int i = 0; i < int'(NUM_IRQ_USED); i++) begin
            acc_onehot[i] = accept && (vec_q == VecW'(i));
        end
        // Set wins over a same-cycle W1C.
        status_d = (status_q & ~w1c) | rise;
        // A host W1C acknowledges service even when a merged edge keeps STATUS set, so the
        // vector can be re-requested. A bit accepted after STATUS was already cleared drops
        // out one cycle later because STATUS is 0.
        inflight_d = (inflight_q & status_q & ~w1c) | acc_onehot;
        mask_d      = (csr_write && csr_address == AddrMask) ?
                      csr_writedata[NUM_IRQ_USED-1:0] : mask_q;
        global_en_d = (csr_write && csr_address == AddrGlobalEn) ?
                      csr_writedata[0] : global_en_q;
        count_d     = count_q + {31'b0, accept};
        eligible    = status_q & ~mask_q & ~inflight_q & {NUM_IRQ_USED{global_en_q}};
        // Descending scan so the lowest eligible index wins.
        pick_vec = '0;
        for (int i = int'(NUM_IRQ_USED) - 1; i >= 0; i--) begin
            if (eligible[i]) pick_vec = VecW'(i);
        end
    end

    // Read mux sees only registered state, so a same-cycle write returns the pre-write value.
    always_comb begin
        rd_data = '0;
        case (csr_address)
            AddrStatus:   rd_data[NUM_IRQ_USED-1:0] = status_q;
            AddrMask:     rd_data[NUM_IRQ_USED-1:0] = mask_q;
            AddrGlobalEn: rd_data[0]                = global_en_q;
            AddrCount:    rd_data[31:0]             = count_q;
            AddrInflight: rd_data[NUM_IRQ_USED-1:0] = inflight_q;
            default:      rd_data                   = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q           <= '0;
            status_q        <= '0;
            mask_q          <= '1;
            inflight_q      <= '0;
            global_en_q     <= 1'b0;
            count_q         <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            src_q           <= irq_src;
            status_q        <= status_d;
            mask_q          <= mask_d;
            inflight_q      <= inflight_d;
            global_en_q     <= global_en_d;
            count_q         <= count_d;
            readdatavalid_q <= csr_read;
            if (csr_read) readdata_q <= rd_data;
        end
    end

    assign csr_readdata      = readdata_q;
    assign csr_readdatavalid = readdatavalid_q;

    // ---------------- Request sequencer ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            vec_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StReq;
                    vec_d   = pick_vec;
                end
            end
            // No retraction: vector stays put until the host takes it.
            StReq: begin
                if (irq_req_ready) begin
                    state_d = StHoldoff;
                    hold_d  = HoldW'(HOLDOFF_CYCLES - 1);
                end
            end
            StHoldoff: begin
                if (hold_q == '0) state_d = StIdle;
                else              hold_d  = hold_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        irq_req_valid  = (state_q == StReq);
        irq_req_vector = vec_q;
    end

endmodule

// File: tb/tb_ofs_asp_irq_ctrl.sv
module tb_ofs_asp_irq_ctrl;

    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  irq_src = '0;
    logic [2:0]  csr_address = '0;
    logic        csr_write = 1'b0;
    logic [63:0] csr_writedata = '0;
    logic        csr_read = 1'b0;
    logic [63:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        irq_req_valid;
    logic [1:0]  irq_req_vector;
    logic        irq_req_ready = 1'b0;

    ofs_asp_irq_ctrl #(
        .NUM_IRQ_LINES  (4),
        .NUM_IRQ_USED   (3),
        .CSR_DATA_WIDTH (64),
        .CSR_ADDR_WIDTH (3),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .irq_src           (irq_src),
        .csr_address       (csr_address),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_read          (csr_read),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .irq_req_valid     (irq_req_valid),
        .irq_req_vector    (irq_req_vector),
        .irq_req_ready     (irq_req_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [63:0] data;
    } csr_vec_t;

    rd_exp_t rd_q[$];
    int      exp_vec[$];
    int      acc_cyc[$];
    int      n_tests = 0;
    int      n_fail = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Read scoreboard: each response pops the oldest expected value.
    always @(negedge clk) begin : rd_mon
        rd_exp_t e;
        if (!reset && csr_readdatavalid) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 64'(csr_readdatavalid), 64'd0);
            end else begin
                e = rd_q.pop_front();
                check(e.name, csr_readdata, e.data);
            end
        end
    end

    // Request scoreboard: valid&ready seen here is taken at the next rising edge.
    always @(negedge clk) begin : vec_mon
        int e;
        if (!reset && irq_req_valid && irq_req_ready) begin
            acc_cyc.push_back(cyc);
            if (exp_vec.size() == 0) begin
                check("vec_unexpected", 64'(irq_req_valid), 64'd0);
            end else begin
                e = exp_vec.pop_front();
                check("vec", 64'(irq_req_vector), 64'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq_src = '0;
        csr_read = 1'b0;
        csr_write = 1'b0;
        irq_req_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        acc_cyc.delete();
        tick(1);
    endtask

    task automatic csr_wr(input logic [2:0] addr, input logic [63:0] data);
        csr_address = addr;
        csr_writedata = data;
        csr_write = 1'b1;
        tick(1);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] addr, input logic [63:0] exp, input string name);
        rd_q.push_back('{data: exp, name: name});
        csr_address = addr;
        csr_read = 1'b1;
        tick(1);
        csr_read = 1'b0;
        tick(1);
    endtask

    task automatic pulse(input logic [2:0] bits);
        irq_src = bits;
        tick(1);
        irq_src = '0;
    endtask

    task automatic setup();
        csr_wr(3'd1, 64'd0);
        csr_wr(3'd2, 64'd1);
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 64'(acc_cyc.size()), 64'(n));
    endtask

    task automatic wait_valid(input int budget, input string name, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!irq_req_valid && waited < budget);
        check(name, 64'(irq_req_valid), 64'd1);
    endtask

    csr_vec_t vecs[19];
    logic [63:0] vexp[19];

    initial begin
        int waited;
        int stable;
        int vcount;

        vecs[0]  = '{1'b0, 3'd0, 64'd0};      vexp[0]  = 64'd0;
        vecs[1]  = '{1'b0, 3'd1, 64'd0};      vexp[1]  = 64'd7;
        vecs[2]  = '{1'b0, 3'd2, 64'd0};      vexp[2]  = 64'd0;
        vecs[3]  = '{1'b0, 3'd3, 64'd0};      vexp[3]  = 64'd0;
        vecs[4]  = '{1'b0, 3'd4, 64'd0};      vexp[4]  = 64'd0;
        vecs[5]  = '{1'b0, 3'd5, 64'd0};      vexp[5]  = 64'd0;
        vecs[6]  = '{1'b0, 3'd7, 64'd0};      vexp[6]  = 64'd0;
        vecs[7]  = '{1'b1, 3'd1, 64'hF8};     vexp[7]  = 64'd0;
        vecs[8]  = '{1'b0, 3'd1, 64'd0};      vexp[8]  = 64'd0;
        vecs[9]  = '{1'b1, 3'd2, 64'd3};      vexp[9]  = 64'd0;
        vecs[10] = '{1'b0, 3'd2, 64'd0};      vexp[10] = 64'd1;
        vecs[11] = '{1'b1, 3'd3, 64'd5};      vexp[11] = 64'd0;
        vecs[12] = '{1'b0, 3'd3, 64'd0};      vexp[12] = 64'd0;
        vecs[13] = '{1'b1, 3'd0, 64'd7};      vexp[13] = 64'd0;
        vecs[14] = '{1'b0, 3'd0, 64'd0};      vexp[14] = 64'd0;
        vecs[15] = '{1'b1, 3'd6, 64'hFFFF};   vexp[15] = 64'd0;
        vecs[16] = '{1'b0, 3'd6, 64'd0};      vexp[16] = 64'd0;
        vecs[17] = '{1'b1, 3'd2, 64'd0};      vexp[17] = 64'd0;
        vecs[18] = '{1'b0, 3'd2, 64'd0};      vexp[18] = 64'd0;

        // Reset state and CSR map.
        do_reset();
        check("rst_valid", 64'(irq_req_valid), 64'd0);
        check("rst_vector", 64'(irq_req_vector), 64'd0);
        check("rst_rdvalid", 64'(csr_readdatavalid), 64'd0);
        check("rst_rdata", csr_readdata, 64'd0);
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) csr_wr(vecs[i].addr, vecs[i].data);
            else csr_rd(vecs[i].addr, vexp[i], $sformatf("csr_vec[%0d]", i));
        end
        // Same-cycle read and write of MASK returns the old value.
        rd_q.push_back('{data: 64'd0, name: "rw_same_cycle"});
        csr_address = 3'd1;
        csr_writedata = 64'd5;
        csr_write = 1'b1;
        csr_read = 1'b1;
        tick(1);
        csr_write = 1'b0;
        csr_read = 1'b0;
        tick(1);
        csr_rd(3'd1, 64'd5, "rw_after");

        // 1: single kernel IRQ.
        do_reset();
        setup();
        irq_req_ready = 1'b1;
        exp_vec.push_back(1);
        pulse(3'b010);
        wait_valid(3, "t1_valid", waited);
        check("t1_latency", 64'(waited <= 3), 64'd1);
        wait_acc(1, 5, "t1_accept");
        tick(2);
        csr_rd(3'd3, 64'd1, "t1_count");
        csr_rd(3'd4, 64'd2, "t1_inflight");

        // 2: simultaneous edges, spacing between requests.
        do_reset();
        setup();
        irq_req_ready = 1'b1;
        exp_vec.push_back(0);
        exp_vec.push_back(2);
        irq_src = 3'b101;
        wait_acc(2, 80, "t2_two_accepts");
        irq_src = '0;
        if (acc_cyc.size() >= 2) check("t2_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(HOLD + 2));
        csr_rd(3'd3, 64'd2, "t2_count");

        // 3: long stall, STATUS cleared while requesting (lost ack).
        do_reset();
        setup();
        pulse(3'b001);
        wait_valid(5, "t3_valid", waited);
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 25) begin
                csr_address = 3'd0;
                csr_writedata = 64'd1;
                csr_write = 1'b1;
            end else begin
                csr_write = 1'b0;
            end
            @(negedge clk);
            if (irq_req_valid && irq_req_vector == 2'd0) stable++;
        end
        tick(1);
        csr_write = 1'b0;
        check("t3_stable", 64'(stable), 64'd50);
        csr_rd(3'd0, 64'd0, "t3_status_cleared");
        check("t3_no_retract", 64'(irq_req_valid), 64'd1);
        exp_vec.push_back(0);
        irq_req_ready = 1'b1;
        wait_acc(1, 5, "t3_accept");
        tick(3);
        csr_rd(3'd4, 64'd0, "t3_inflight");
        csr_rd(3'd3, 64'd1, "t3_count");

        // 4: W1C collides with a fresh edge; vector 1 re-requested after hold-off.
        do_reset();
        setup();
        irq_req_ready = 1'b1;
        exp_vec.push_back(1);
        pulse(3'b010);
        wait_acc(1, 10, "t4_first");
        irq_src = 3'b010;
        csr_address = 3'd0;
        csr_writedata = 64'd2;
        csr_write = 1'b1;
        tick(1);
        csr_write = 1'b0;
        irq_src = '0;
        csr_rd(3'd0, 64'd2, "t4_status_set_wins");
        exp_vec.push_back(1);
        wait_acc(2, 40, "t4_second");
        if (acc_cyc.size() >= 2) check("t4_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(HOLD + 2));
        csr_rd(3'd3, 64'd2, "t4_count");

        // 5: everything masked, then unmasked.
        do_reset();
        csr_wr(3'd2, 64'd1);
        irq_req_ready = 1'b1;
        pulse(3'b111);
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (irq_req_valid) vcount++;
        end
        check("t5_masked_no_valid", 64'(vcount), 64'd0);
        tick(1);
        csr_rd(3'd0, 64'd7, "t5_status");
        exp_vec.push_back(0);
        exp_vec.push_back(1);
        exp_vec.push_back(2);
        csr_wr(3'd1, 64'd0);
        wait_acc(3, 80, "t5_three");

        // 6: COUNT wrap, then reset in the middle of a request.
        do_reset();
        setup();
        irq_req_ready = 1'b1;
        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        tick(1);
        csr_rd(3'd3, 64'hFFFF_FFFF, "t6_preload");
        exp_vec.push_back(2);
        pulse(3'b100);
        wait_acc(1, 10, "t6_accept");
        irq_req_ready = 1'b0;
        tick(1);
        csr_rd(3'd3, 64'd0, "t6_count_wrap");
        pulse(3'b001);
        wait_valid(30, "t6_valid", waited);
        check("t6_vector", 64'(irq_req_vector), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_reset_drops_valid", 64'(irq_req_valid), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(3);

        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        check("vec_queue_drained", 64'(exp_vec.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
